fir_channel_scheduler: RTL and testbench

Round-robin scheduler that shares one multi-context FIR datapath among NUM_CH AXI-Stream sample channels. It grants one channel at a time, forwards that channel's samples to the FIR with a channel tag, and records each issued tag in an in-order tag FIFO. When results return, it pops the FIFO and labels each result with its source channel. It sits between the per-channel ADC/stream sources and the FIR filter instance; the FIR selects its per-channel delay line from m_axis_fir_tuser.

---
 rtl/fir_channel_scheduler.sv | 151 +++++++++++++++
 tb/tb_fir_channel_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_channel_scheduler.sv
// Round-robin scheduler sharing one multi-context FIR among NUM_CH sample streams.
// Issued channel tags are queued in order so that returning results can be labelled.
module fir_channel_scheduler #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 16,
  parameter int OUT_W     = 32,
  parameter int BURST     = 4,
  parameter int TAG_DEPTH = 16,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W    = $clog2(TAG_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] s_axis_ch_tdata,
  input  logic [NUM_CH-1:0]        s_axis_ch_tvalid,
  output logic [NUM_CH-1:0]        s_axis_ch_tready,
  output logic [DATA_W-1:0]        m_axis_fir_tdata,
  output logic [CH_W-1:0]          m_axis_fir_tuser,
  output logic                     m_axis_fir_tvalid,
  input  logic                     m_axis_fir_tready,
  input  logic [OUT_W-1:0]         s_axis_fir_tdata,
  input  logic                     s_axis_fir_tvalid,
  output logic                     s_axis_fir_tready,
  output logic [OUT_W-1:0]         m_axis_out_tdata,
  output logic [CH_W-1:0]          m_axis_out_tid,
  output logic                     m_axis_out_tvalid,
  input  logic                     m_axis_out_tready,
  output logic [CNT_W-1:0]         tag_count,
  output logic                     err_orphan
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int BC_W  = $clog2(BURST) + 1;

  typedef enum logic {IDLE, SERVE} state_t;

  state_t            state, state_nxt;
  logic [CH_W-1:0]   grant, grant_nxt, rr_ptr, rr_ptr_nxt, ptr_after;
  logic [BC_W-1:0]   burst_cnt, burst_cnt_nxt;
  logic [CH_W:0]     arb;
  logic              issue, pop, tag_full, tag_empty, granted_valid;
  logic [CH_W-1:0]   tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;

  // Returns {found, index}: first set request at or after start, wrapping.
  function automatic logic [CH_W:0] pick(input logic [NUM_CH-1:0] req,
                                         input logic [CH_W-1:0]   start);
    logic            found;
    logic [CH_W-1:0] idx;
    int              c;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = int'(start) + i;
      if (c >= NUM_CH) c -= NUM_CH;
      if (!found && req[CH_W'(c)]) begin
        found = 1'b1;
        idx   = CH_W'(c);
      end
    end
    return {found, idx};
  endfunction

  assign tag_full      = (tag_count == CNT_W'(TAG_DEPTH));
  assign tag_empty     = (tag_count == '0);
  assign granted_valid = s_axis_ch_tvalid[grant];
  assign ptr_after     = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + CH_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      rr_ptr    <= rr_ptr_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    grant_nxt         = grant;
    rr_ptr_nxt        = rr_ptr;
    burst_cnt_nxt     = burst_cnt;
    arb               = '0;
    issue             = 1'b0;
    m_axis_fir_tdata  = '0;
    m_axis_fir_tuser  = '0;
    m_axis_fir_tvalid = 1'b0;
    s_axis_ch_tready  = '0;
    case (state)
      IDLE: begin
        arb = pick(s_axis_ch_tvalid, rr_ptr);
        if (arb[CH_W]) begin
          grant_nxt     = arb[CH_W-1:0];
          burst_cnt_nxt = '0;
          state_nxt     = SERVE;
        end
      end
      SERVE: begin
        m_axis_fir_tdata        = s_axis_ch_tdata[grant*DATA_W +: DATA_W];
        m_axis_fir_tuser        = grant;
        m_axis_fir_tvalid       = granted_valid & ~tag_full;
        s_axis_ch_tready[grant] = m_axis_fir_tready & ~tag_full;
        issue                   = m_axis_fir_tvalid & m_axis_fir_tready;
        if (issue) burst_cnt_nxt = burst_cnt + BC_W'(1);
        // Searching from grant+1 leaves the current grant last, so it only wins when alone.
        if ((issue && burst_cnt == BC_W'(BURST - 1)) || !granted_valid) begin
          rr_ptr_nxt    = ptr_after;
          burst_cnt_nxt = '0;
          arb           = pick(s_axis_ch_tvalid, ptr_after);
          if (arb[CH_W]) grant_nxt = arb[CH_W-1:0];
          else           state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pop               = s_axis_fir_tvalid & s_axis_fir_tready;
  assign m_axis_out_tdata  = s_axis_fir_tdata;
  assign m_axis_out_tid    = tag_empty ? '0 : tag_mem[rd_ptr];
  assign m_axis_out_tvalid = s_axis_fir_tvalid & ~tag_empty;
  assign s_axis_fir_tready = m_axis_out_tready & ~tag_empty;

  always_ff @(posedge clk) begin
    if (issue) tag_mem[wr_ptr] <= grant;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      tag_count  <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (issue) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({issue, pop})
        2'b10:   tag_count <= tag_count + CNT_W'(1);
        2'b01:   tag_count <= tag_count - CNT_W'(1);
        default: tag_count <= tag_count;
      endcase
      if (s_axis_fir_tvalid && tag_empty) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Self-checking bench: directed vector table, hand sequences and a randomized run,
// all checked against a queue-based reference model of the scheduler and a bench FIR.
module tb_fir_channel_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] ch_tdata;
  logic [3:0]  ch_tvalid, ch_tready;
  logic [15:0] fir_tdata;
  logic [1:0]  fir_tuser;
  logic        fir_tvalid, fir_tready;
  logic [31:0] res_tdata;
  logic        res_tvalid, res_tready;
  logic [31:0] out_tdata;
  logic [1:0]  out_tid;
  logic        out_tvalid, out_tready;
  logic [4:0]  tag_count;
  logic        err_orphan;

  always #5 clk = ~clk;

  fir_channel_scheduler dut (
    .clk(clk), .reset(reset),
    .s_axis_ch_tdata(ch_tdata), .s_axis_ch_tvalid(ch_tvalid), .s_axis_ch_tready(ch_tready),
    .m_axis_fir_tdata(fir_tdata), .m_axis_fir_tuser(fir_tuser),
    .m_axis_fir_tvalid(fir_tvalid), .m_axis_fir_tready(fir_tready),
    .s_axis_fir_tdata(res_tdata), .s_axis_fir_tvalid(res_tvalid), .s_axis_fir_tready(res_tready),
    .m_axis_out_tdata(out_tdata), .m_axis_out_tid(out_tid),
    .m_axis_out_tvalid(out_tvalid), .m_axis_out_tready(out_tready),
    .tag_count(tag_count), .err_orphan(err_orphan)
  );

  localparam int NCH = 4, BURST = 4, DEPTH = 16;

  typedef struct { int due; logic [31:0] res; } fir_t;
  typedef struct { logic [3:0] mask; string seq; } vec_t;

  int   tests = 0, fails = 0, cyc = 0;
  bit   rst = 1'b1, skip = 1'b1, rnd = 1'b0, force_fv = 1'b0;
  logic [3:0] v_fix = 4'hf;
  logic rdy_fix = 1'b1, ordy_fix = 1'b1;
  int   lat_fix = 3;

  int   owner = -1, mcnt = 0, mptr = 0;
  bit   err_m = 1'b0;
  int   tq[$];
  fir_t pipe[$];
  int   ilog[$], rlog[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int first_req(input logic [3:0] v, input int from);
    for (int i = 0; i < NCH; i++)
      if (v[(from + i) % NCH]) return (from + i) % NCH;
    return -1;
  endfunction

  task automatic step();
    logic [3:0]  v, exp_rdy;
    logic        rdy, ordy, fv, exp_fv, full, empty, issue, pop;
    logic [31:0] fd;
    logic [15:0] d[4];
    int          lat;
    if (rnd) begin
      v = 4'($urandom); rdy = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0); lat = $urandom_range(1, 6);
    end else begin
      v = v_fix; rdy = rdy_fix; ordy = ordy_fix; lat = lat_fix;
    end
    for (int k = 0; k < NCH; k++) begin
      d[k] = 16'($urandom);
      ch_tdata[k*16 +: 16] = d[k];
    end
    fv = force_fv || (pipe.size() > 0 && pipe[0].due <= cyc);
    fd = (!force_fv && pipe.size() > 0) ? pipe[0].res : 32'h0;
    reset = rst; ch_tvalid = v; fir_tready = rdy;
    res_tvalid = fv; res_tdata = fd; out_tready = ordy;
    #1;
    if (rst) begin
      if (!skip) begin
        chk("rst_tag_count", tag_count, 0);
        chk("rst_err_orphan", err_orphan, 0);
        chk("rst_fir_tvalid", fir_tvalid, 0);
        chk("rst_ch_tready", ch_tready, 0);
        chk("rst_out_tvalid", out_tvalid, 0);
        chk("rst_res_tready", res_tready, 0);
        chk("rst_fir_tuser", fir_tuser, 0);
      end
      owner = -1; mcnt = 0; mptr = 0; err_m = 1'b0;
      tq.delete(); pipe.delete();
    end else begin
      full  = (tq.size() >= DEPTH);
      empty = (tq.size() == 0);
      if (owner < 0) begin
        exp_fv = 1'b0; exp_rdy = 4'h0;
        chk("fir_tuser", fir_tuser, 0);
        chk("fir_tdata", fir_tdata, 0);
      end else begin
        exp_fv  = v[owner] && !full;
        exp_rdy = (rdy && !full) ? (4'b0001 << owner) : 4'h0;
        chk("fir_tuser", fir_tuser, owner);
        chk("fir_tdata", fir_tdata, d[owner]);
      end
      chk("fir_tvalid", fir_tvalid, exp_fv);
      chk("ch_tready", ch_tready, exp_rdy);
      chk("out_tvalid", out_tvalid, fv && !empty);
      chk("res_tready", res_tready, ordy && !empty);
      chk("out_tdata", out_tdata, fd);
      if (!empty) chk("out_tid", out_tid, tq[0]);
      chk("tag_count", tag_count, tq.size());
      chk("err_orphan", err_orphan, err_m);
      ilog.push_back((fir_tvalid && rdy) ? int'(fir_tuser) : -1);
      if (out_tvalid && ordy) rlog.push_back(int'(out_tid));
      issue = exp_fv && rdy;
      pop   = fv && ordy && !empty;
      if (fv && empty) err_m = 1'b1;
      if (pop) begin
        void'(tq.pop_front());
        if (pipe.size() > 0) void'(pipe.pop_front());
      end
      if (issue) begin
        tq.push_back(owner);
        pipe.push_back('{cyc + lat, {~d[owner], d[owner]}});
      end
      if (owner < 0) begin
        owner = first_req(v, mptr); mcnt = 0;
      end else begin
        if (issue) mcnt++;
        if ((issue && mcnt == BURST) || !v[owner]) begin
          mptr = (owner + 1) % NCH;
          owner = first_req(v, mptr);
          mcnt = 0;
        end
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1; skip = 1'b1; step();
    skip = 1'b0; step();
    rst = 1'b0;
  endtask

  vec_t  vecs[6];
  string exp_s;
  int    exp_drop[9];

  initial begin
    vecs[0] = '{4'b1111, "000011112222"};
    vecs[1] = '{4'b0100, "222222222222"};
    vecs[2] = '{4'b1010, "111133331111"};
    vecs[3] = '{4'b0011, "000011110000"};
    vecs[4] = '{4'b1001, "000033330000"};
    vecs[5] = '{4'b1000, "333333333333"};
    reset = 1'b1; ch_tvalid = '0; ch_tdata = '0; fir_tready = 1'b0;
    res_tvalid = 1'b0; res_tdata = '0; out_tready = 1'b0;
    @(negedge clk);

    // Constant request masks from reset: exact grant order, no bubbles.
    for (int n = 0; n < 6; n++) begin
      v_fix = vecs[n].mask; rdy_fix = 1'b1; ordy_fix = 1'b1; lat_fix = 3;
      do_reset();
      ilog.delete();
      repeat (13) step();
      chk("vec_first_cycle_idle", ilog[0], -1);
      for (int i = 0; i < 12; i++)
        chk($sformatf("vec%0d_tuser%0d", n, i), ilog[i+1], int'(vecs[n].seq[i]) - 48);
    end

    // Fill the tag FIFO with results held back, then drain in issue order.
    v_fix = 4'hf; ordy_fix = 1'b0; lat_fix = 5;
    do_reset();
    repeat (20) step();
    chk("fill_tag_count", tag_count, 16);
    chk("fill_fir_tvalid", fir_tvalid, 0);
    chk("fill_ch_tready", ch_tready, 0);
    rlog.delete();
    v_fix = 4'h0; ordy_fix = 1'b1;
    repeat (30) step();
    chk("drain_count", rlog.size(), 16);
    exp_s = "0000111122223333";
    for (int i = 0; i < 16 && i < rlog.size(); i++)
      chk($sformatf("drain_tid%0d", i), rlog[i], int'(exp_s[i]) - 48);
    chk("drain_tag_count", tag_count, 0);

    // Ch1 drops after two samples; search resumes after ch1, so ch3 beats ch0.
    v_fix = 4'b0010; lat_fix = 3;
    do_reset();
    ilog.delete();
    repeat (3) step();
    v_fix = 4'b1001;
    repeat (6) step();
    exp_drop = '{-1, 1, 1, -1, 3, 3, 3, 3, 0};
    for (int i = 0; i < 9; i++) chk($sformatf("drop_issue%0d", i), ilog[i], exp_drop[i]);

    // Orphan result with nothing outstanding.
    v_fix = 4'h0;
    do_reset();
    force_fv = 1'b1; step();
    force_fv = 1'b0;
    repeat (4) step();
    chk("orphan_sticky", err_orphan, 1);
    chk("orphan_tag_count", tag_count, 0);

    // Randomized traffic, including a reset in the middle of activity.
    rnd = 1'b1;
    do_reset();
    repeat (3000) step();
    do_reset();
    repeat (1500) step();
    rnd = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
